// File: rtl/sram_pkg.sv
// Shared constants and FSM state encoding for the external SRAM controller.
package sram_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned WORD_AW = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LO,
        ST_LO_REC,
        ST_HI,
        ST_HI_REC,
        ST_ACK
    } state_t;

endpackage

// File: rtl/sram_phy.sv
// Pin-side register stage for the async SRAM: registered controls, write-data
// tristate driver and per-port read capture registers.
module sram_phy
    import sram_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               csn_d,
    input  logic               oen_d,
    input  logic               wen_d,
    input  logic               oe_d,
    input  logic [SRAM_AW-1:0] a_d,
    input  logic [SRAM_DW-1:0] wdata_d,
    input  logic               cap_lo,
    input  logic               cap_hi,
    input  logic               cap_port,
    output logic [31:0]        rdata0,
    output logic [31:0]        rdata1,
    inout  logic [SRAM_DW-1:0] io_sram_d,
    output logic [SRAM_AW-1:0] o_sram_a,
    output logic               o_sram_csn,
    output logic               o_sram_oen,
    output logic               o_sram_wen
);

    logic               oe;
    logic [SRAM_DW-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sram_a   <= '0;
            o_sram_csn <= 1'b1;
            o_sram_oen <= 1'b1;
            o_sram_wen <= 1'b1;
            oe         <= 1'b0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            o_sram_a   <= a_d;
            o_sram_csn <= csn_d;
            o_sram_oen <= oen_d;
            o_sram_wen <= wen_d;
            oe         <= oe_d;
            wdata_q    <= wdata_d;
            // Only the owning port's register is touched, so the other port's data holds
            if (cap_lo) begin
                if (cap_port) rdata1[15:0] <= io_sram_d;
                else          rdata0[15:0] <= io_sram_d;
            end
            if (cap_hi) begin
                if (cap_port) rdata1[31:16] <= io_sram_d;
                else          rdata0[31:16] <= io_sram_d;
            end
        end
    end

    assign io_sram_d = oe ? wdata_q : 'z;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer turning 32-bit word accesses
// into two 16-bit async SRAM cycles.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_m0_req,
    input  logic               i_m0_we,
    input  logic [WORD_AW-1:0] i_m0_addr,
    input  logic [31:0]        i_m0_wdata,
    input  logic [1:0]         i_m0_hen,
    output logic [31:0]        o_m0_rdata,
    output logic               o_m0_ack,
    input  logic               i_m1_req,
    input  logic               i_m1_we,
    input  logic [WORD_AW-1:0] i_m1_addr,
    input  logic [31:0]        i_m1_wdata,
    input  logic [1:0]         i_m1_hen,
    output logic [31:0]        o_m1_rdata,
    output logic               o_m1_ack,
    inout  logic [SRAM_DW-1:0] io_sram_d,
    output logic [SRAM_AW-1:0] o_sram_a,
    output logic               o_sram_csn,
    output logic               o_sram_oen,
    output logic               o_sram_wen
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               win, win_nxt, prio;
    logic               op_we;
    logic [1:0]         op_hen;
    logic [WORD_AW-1:0] op_addr;
    logic [31:0]        op_wdata;
    logic               sel_we;
    logic [1:0]         sel_hen;
    logic [WORD_AW-1:0] sel_addr;
    logic [31:0]        sel_wdata;
    logic               any_req;
    logic               csn_d, oen_d, wen_d, oe_d;
    logic [SRAM_AW-1:0] a_d;
    logic [SRAM_DW-1:0] wdata_d;
    logic               cap_lo, cap_hi;

    assign any_req = i_m0_req | i_m1_req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        win_nxt   = win;
        case (state)
            ST_IDLE: if (any_req) begin
                win_nxt   = (i_m0_req && i_m1_req) ? prio : i_m1_req;
                state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (!op_we || op_hen[0]) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = CNT_LOAD;
                end else if (op_hen[1]) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = ST_ACK;
                end
            end
            ST_LO: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (op_we) begin
                    state_nxt = ST_LO_REC;
                end else begin
                    state_nxt = ST_HI;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_LO_REC: begin
                if (op_hen[1]) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = ST_ACK;
                end
            end
            ST_HI: begin
                if (cnt != 4'd0)  cnt_nxt   = cnt - 4'd1;
                else if (op_we)   state_nxt = ST_HI_REC;
                else              state_nxt = ST_ACK;
            end
            ST_HI_REC: state_nxt = ST_ACK;
            ST_ACK:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_we    = win_nxt ? i_m1_we    : i_m0_we;
        sel_hen   = win_nxt ? i_m1_hen   : i_m0_hen;
        sel_addr  = win_nxt ? i_m1_addr  : i_m0_addr;
        sel_wdata = win_nxt ? i_m1_wdata : i_m0_wdata;
    end

    // Pin commands are decoded from the next state so the phy registers line up with it
    always_comb begin
        csn_d   = 1'b1;
        oen_d   = 1'b1;
        wen_d   = 1'b1;
        oe_d    = 1'b0;
        a_d     = o_sram_a;
        wdata_d = '0;
        case (state_nxt)
            ST_GRANT: begin
                csn_d = 1'b0;
                a_d   = {sel_addr, sel_we & ~sel_hen[0]};
            end
            ST_LO, ST_LO_REC: begin
                csn_d   = 1'b0;
                a_d     = {op_addr, 1'b0};
                oe_d    = op_we;
                wdata_d = op_wdata[15:0];
                if (state_nxt == ST_LO) begin
                    oen_d = op_we;
                    wen_d = ~op_we;
                end
            end
            ST_HI, ST_HI_REC: begin
                csn_d   = 1'b0;
                a_d     = {op_addr, 1'b1};
                oe_d    = op_we;
                wdata_d = op_wdata[31:16];
                if (state_nxt == ST_HI) begin
                    oen_d = op_we;
                    wen_d = ~op_we;
                end
            end
            default: ;
        endcase
    end

    assign cap_lo = (state == ST_LO) && !op_we && (cnt == 4'd0);
    assign cap_hi = (state == ST_HI) && !op_we && (cnt == 4'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            win      <= 1'b0;
            prio     <= 1'b0;
            op_we    <= 1'b0;
            op_hen   <= '0;
            op_addr  <= '0;
            op_wdata <= '0;
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            win   <= win_nxt;
            if (state == ST_IDLE && any_req) begin
                prio     <= ~win_nxt;
                op_we    <= sel_we;
                op_hen   <= sel_hen;
                op_addr  <= sel_addr;
                op_wdata <= sel_wdata;
            end
            o_m0_ack <= (state_nxt == ST_ACK) && !win_nxt;
            o_m1_ack <= (state_nxt == ST_ACK) &&  win_nxt;
        end
    end

    sram_phy u_phy (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .csn_d      (csn_d),
        .oen_d      (oen_d),
        .wen_d      (wen_d),
        .oe_d       (oe_d),
        .a_d        (a_d),
        .wdata_d    (wdata_d),
        .cap_lo     (cap_lo),
        .cap_hi     (cap_hi),
        .cap_port   (win),
        .rdata0     (o_m0_rdata),
        .rdata1     (o_m1_rdata),
        .io_sram_d  (io_sram_d),
        .o_sram_a   (o_sram_a),
        .o_sram_csn (o_sram_csn),
        .o_sram_oen (o_sram_oen),
        .o_sram_wen (o_sram_wen)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: W=2 instance with an SRAM model, plus W=1
// and W=15 instances checked for latency and last-cycle read capture.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [16:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [1:0]  m0_hen, m1_hen;
    logic        m0_ack, m1_ack;
    wire  [15:0] sram_d;
    logic [17:0] sram_a;
    logic        csn, oen, wen;

    sram_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .i_m0_hen(m0_hen), .o_m0_rdata(m0_rdata), .o_m0_ack(m0_ack),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .i_m1_hen(m1_hen), .o_m1_rdata(m1_rdata), .o_m1_ack(m1_ack),
        .io_sram_d(sram_d), .o_sram_a(sram_a), .o_sram_csn(csn), .o_sram_oen(oen), .o_sram_wen(wen)
    );

    // SRAM model: read data is valid only on the W-th consecutive oen-low cycle at one address
    bit   [15:0] mem [0:262143];
    int          run = 0;
    logic [17:0] a_last = '0;
    always @(negedge clk) begin
        run    = (!csn && !oen) ? ((sram_a == a_last) ? run + 1 : 1) : 0;
        a_last = sram_a;
    end
    assign sram_d = (!csn && !oen) ? ((run == 2) ? mem[sram_a] : 16'h5A5A) : 16'hzzzz;
    always @(posedge wen) if (!csn && rst_n) mem[sram_a] = sram_d;

    int   wen_falls = 0, ack0_cnt = 0, ack1_cnt = 0, ack_long = 0, ack_both = 0, contention = 0;
    logic wen_q = 1'b1, ack0_q = 1'b0, ack1_q = 1'b0;
    always @(negedge clk) begin
        if (wen_q && !wen) wen_falls++;
        if (m0_ack) ack0_cnt++;
        if (m1_ack) ack1_cnt++;
        if ((m0_ack && ack0_q) || (m1_ack && ack1_q)) ack_long++;
        if (m0_ack && m1_ack) ack_both++;
        if (!oen && u_dut.u_phy.oe) contention++;
        wen_q  = wen;
        ack0_q = m0_ack;
        ack1_q = m1_ack;
    end

    // Auxiliary W=1 (a) and W=15 (b) instances sharing operands, separate requests
    logic        ax_we, req_a, req_b, ack_a, ack_b, ack1_a, ack1_b, csn_a, csn_b, oen_a, oen_b, wen_a, wen_b;
    logic [16:0] ax_addr;
    logic [31:0] ax_wdata, rd_a, rd_b, rd1_a, rd1_b;
    logic [1:0]  ax_hen;
    logic [17:0] a_a, a_b;
    wire  [15:0] d_a, d_b;

    sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(req_a), .i_m0_we(ax_we), .i_m0_addr(ax_addr), .i_m0_wdata(ax_wdata),
        .i_m0_hen(ax_hen), .o_m0_rdata(rd_a), .o_m0_ack(ack_a),
        .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(17'd0), .i_m1_wdata(32'd0),
        .i_m1_hen(2'b00), .o_m1_rdata(rd1_a), .o_m1_ack(ack1_a),
        .io_sram_d(d_a), .o_sram_a(a_a), .o_sram_csn(csn_a), .o_sram_oen(oen_a), .o_sram_wen(wen_a)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(req_b), .i_m0_we(ax_we), .i_m0_addr(ax_addr), .i_m0_wdata(ax_wdata),
        .i_m0_hen(ax_hen), .o_m0_rdata(rd_b), .o_m0_ack(ack_b),
        .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(17'd0), .i_m1_wdata(32'd0),
        .i_m1_hen(2'b00), .o_m1_rdata(rd1_b), .o_m1_ack(ack1_b),
        .io_sram_d(d_b), .o_sram_a(a_b), .o_sram_csn(csn_b), .o_sram_oen(oen_b), .o_sram_wen(wen_b)
    );

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hC35A;
    endfunction

    int          run_a = 0, run_b = 0;
    logic [17:0] alast_a = '0, alast_b = '0;
    always @(negedge clk) begin
        run_a   = (!csn_a && !oen_a) ? ((a_a == alast_a) ? run_a + 1 : 1) : 0;
        alast_a = a_a;
        run_b   = (!csn_b && !oen_b) ? ((a_b == alast_b) ? run_b + 1 : 1) : 0;
        alast_b = a_b;
    end
    assign d_a = (!csn_a && !oen_a) ? ((run_a == 1)  ? pat(a_a) : 16'h5A5A) : 16'hzzzz;
    assign d_b = (!csn_b && !oen_b) ? ((run_b == 15) ? pat(a_b) : 16'h5A5A) : 16'hzzzz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; returns posedges until ack (-1 on timeout)
    task automatic xfer(input bit port, input bit we, input logic [1:0] hen, input logic [16:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '0;
        if (port) begin
            m1_we = we; m1_hen = hen; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_hen = hen; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (port ? m1_ack : m0_ack) begin
                lat = n;
                rd  = port ? m1_rdata : m0_rdata;
                break;
            end
        end
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    task automatic ax_xfer(input bit we, input logic [1:0] hen, input logic [16:0] addr, input logic [31:0] wd,
                           output int la, output int lb, output logic [31:0] ra, output logic [31:0] rb);
        la = -1; lb = -1; ra = '0; rb = '0;
        ax_we = we; ax_hen = hen; ax_addr = addr; ax_wdata = wd;
        req_a = 1'b1; req_b = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (ack_a && la < 0) begin la = n; ra = rd_a; req_a = 1'b0; end
            if (ack_b && lb < 0) begin lb = n; rb = rd_b; req_b = 1'b0; end
            if (la >= 0 && lb >= 0) break;
        end
        req_a = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
    endtask

    int          lat, lb, w0, a0, a1, seen;
    logic [31:0] rd, rb;
    logic [3:0]  order;
    logic [31:0] first_rd0, first_rd1;

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_hen = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_hen = '0;
        req_a = 0; req_b = 0; ax_we = 0; ax_addr = '0; ax_wdata = '0; ax_hen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn",    csn, 1);
        check("rst_oen",    oen, 1);
        check("rst_wen",    wen, 1);
        check("rst_addr",   sram_a, 0);
        check("rst_acks",   {m0_ack, m1_ack}, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_rdata1", m1_rdata, 0);
        check("rst_bus_oe", u_dut.u_phy.oe, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write then read back
        w0 = wen_falls;
        xfer(0, 1, 2'b11, 17'h17ABC, 32'hDEADBEEF, lat, rd);
        check("wr_full_lat", lat, 8);
        check("wr_full_pulses", wen_falls - w0, 2);
        check("mem_lo", mem[18'h2F578], 16'hBEEF);
        check("mem_hi", mem[18'h2F579], 16'hDEAD);
        @(posedge clk); #1;
        check("ack_one_cycle", {m0_ack, m1_ack}, 0);
        xfer(0, 0, 2'b00, 17'h17ABC, 32'h0, lat, rd);
        check("rd_lat", lat, 6);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_other_ack", m1_ack, 0);
        @(posedge clk); #1;

        // High-half-only write
        w0 = wen_falls;
        xfer(0, 1, 2'b10, 17'h17ABC, 32'h12345678, lat, rd);
        check("wr_hi_lat", lat, 5);
        check("wr_hi_pulses", wen_falls - w0, 1);
        @(posedge clk); #1;
        xfer(0, 0, 2'b11, 17'h17ABC, 32'h0, lat, rd);
        check("rd_after_hi", rd, 32'h1234BEEF);
        @(posedge clk); #1;

        // Port 1: low-half write, empty write, readback
        w0 = wen_falls;
        xfer(1, 1, 2'b01, 17'h00005, 32'hAAAA5555, lat, rd);
        check("wr_lo_lat", lat, 5);
        check("wr_lo_pulses", wen_falls - w0, 1);
        @(posedge clk); #1;
        w0 = wen_falls;
        xfer(1, 1, 2'b00, 17'h00005, 32'hFFFFFFFF, lat, rd);
        check("wr_empty_lat", lat, 2);
        check("wr_empty_pulses", wen_falls - w0, 0);
        @(posedge clk); #1;
        xfer(1, 0, 2'b00, 17'h00005, 32'h0, lat, rd);
        check("m1_rd_data", rd, 32'h00005555);

        // Write on m0 then read on m1 raised during the write's ack cycle
        @(posedge clk); #1;
        xfer(0, 1, 2'b11, 17'h00100, 32'hCAFEF00D, lat, rd);
        check("wr_b2b_lat", lat, 8);
        xfer(1, 0, 2'b11, 17'h00100, 32'h0, lat, rd);
        check("rd_b2b_lat", lat, 7);
        check("rd_b2b_data", rd, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("ack0_count", ack0_cnt, 5);
        check("ack1_count", ack1_cnt, 4);

        // Reset in the middle of a write's low half
        a0 = ack0_cnt;
        seen = 0;
        m0_we = 1; m0_hen = 2'b11; m0_addr = 17'h00200; m0_wdata = 32'h11112222; m0_req = 1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (!wen) begin seen = 1; break; end
        end
        check("rst_mid_wen_low_seen", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wen", wen, 1);
        check("rst_mid_csn", csn, 1);
        check("rst_mid_bus_oe", u_dut.u_phy.oe, 0);
        m0_req = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_no_ack", ack0_cnt - a0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Both ports held from reset: grants alternate starting with m0
        m0_we = 0; m0_addr = 17'h17ABC; m1_we = 0; m1_addr = 17'h00005;
        m0_req = 1; m1_req = 1;
        order = '0; seen = 0; first_rd0 = '0; first_rd1 = '0;
        for (int n = 0; n < 60 && seen < 4; n++) begin
            @(posedge clk); #1;
            if (m0_ack) begin
                order = {order[2:0], 1'b0};
                if (seen == 0) first_rd0 = m0_rdata;
                seen++;
            end else if (m1_ack) begin
                order = {order[2:0], 1'b1};
                if (seen == 1) first_rd1 = m1_rdata;
                seen++;
            end
        end
        m0_req = 0; m1_req = 0;
        check("arb_grants", seen, 4);
        check("arb_order", order, 4'b0101);
        check("arb_rd0", first_rd0, 32'h1234BEEF);
        check("arb_rd1", first_rd1, 32'h00005555);
        repeat (3) @(posedge clk);
        #1;

        check("ack_long", ack_long, 0);
        check("ack_both", ack_both, 0);
        check("bus_contention", contention, 0);

        // W=1 and W=15 latencies and last-cycle capture (word 3 -> halfwords 6/7)
        ax_xfer(0, 2'b11, 17'h00003, 32'h0, lat, lb, rd, rb);
        check("w1_rd_lat", lat, 4);
        check("w15_rd_lat", lb, 32);
        check("w1_rd_data", rd, 32'hC35DC35C);
        check("w15_rd_data", rb, 32'hC35DC35C);
        ax_xfer(1, 2'b11, 17'h00003, 32'h01020304, lat, lb, rd, rb);
        check("w1_wr_full_lat", lat, 6);
        check("w15_wr_full_lat", lb, 34);
        ax_xfer(1, 2'b01, 17'h00003, 32'h01020304, lat, lb, rd, rb);
        check("w1_wr_half_lat", lat, 4);
        check("w15_wr_half_lat", lb, 18);
        ax_xfer(1, 2'b00, 17'h00003, 32'h01020304, lat, lb, rd, rb);
        check("w1_wr_empty_lat", lat, 2);
        check("w15_wr_empty_lat", lb, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
